word_sel_mux: RTL and testbench
===============================

Name: word_sel_mux

Overview:
- Parametrised successor to the 2:1 byte-select stage of the Booth multiplier datapath.
- Selects one W-bit word from NCH input channels. Selection is either a fixed index or round-robin arbitration.
- Delivers the chosen word through a registered output with valid/ready handshake and a skid buffer, so the partial-product/adder stages can stall it without losing data.

Parameters:
- WIDTH, 8, data word width in bits.
- NCH, 2, number of input channels (≥2).
- SEL_W, $clog2(NCH), width of channel index (derived, not overridden).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_data  in  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  NCH  per-channel word valid.
- in_ready  out  NCH  per-channel accept; at most one bit high.
- mode  in  1  0 = fixed select via sel; 1 = round-robin.
- sel  in  SEL_W  channel index used when mode=0.
- out_data  out  WIDTH  selected word (registered).
- out_chan  out  SEL_W  index of channel that supplied out_data.
- out_valid  out  1  out_data/out_chan valid.
- out_ready  in  1  downstream accept.

Behaviour:
- Reset (rst_n=0 at clk edge): out_valid=0, out_data=0, out_chan=0, skid empty, rr pointer=0. in_ready=0 while rst_n=0. Reset mid-transfer discards the output and skid words.
- Grant (combinational):
  - mode=0: grant=sel if sel<NCH and in_valid[sel]. Otherwise there is no grant.
  - mode=1: lowest index ≥ptr (wrapping modulo NCH) with in_valid set. There is no grant if all in_valid=0.
- in_ready[g]=grant_any & ~skid_valid; all other bits are 0. Transfer on channel g = in_valid[g] & in_ready[g].
- Latency: word accepted at edge N appears on out_data/out_valid after edge N. One-cycle latency; one word per cycle sustained while out_ready=1.
- Output stage, per edge:
  - out_valid=0 or out_ready=1 (output free): load from skid if skid_valid, else from the input transfer.
  - If the output stalls (out_valid=1, out_ready=0) and an input transfer occurs, the word goes to skid. skid_valid=1 deasserts all in_ready the next cycle.
  - Skid drains to output when out_ready=1. A same-cycle input transfer cannot occur because in_ready=0 while skid full.
  - No word is ever dropped or duplicated; order is strictly acceptance order.
- Round-robin pointer: on each transfer in mode=1, ptr=(g+1) mod NCH, wrapping from NCH-1 to 0. ptr holds when there is no transfer and holds while mode=0. Switching mode takes effect on the next grant evaluation; no state flush.
- sel≥NCH (non-power-of-two NCH) in mode=0: no grant, all in_ready=0, output drains normally.
- Simultaneous output pop and skid drain: the skid word moves to output in the same edge; skid_valid clears.
- out_data/out_chan stay stable while out_valid=1 and out_ready=0.

Optional Feature:
- Macro WORD_SEL_PARITY_EN.
- Defined: adds output port out_par (1 bit) = even parity (XOR reduction) of out_data. It is registered alongside out_data, travels through the skid buffer, and resets to 0.
- Undefined: port absent; no parity logic.

Decomposition:
- Shared package word_sel_pkg: mode encoding constants MODE_FIXED=1'b0, MODE_RR=1'b1, and a function for the round-robin next-index wrap.
- One natural sub-module: word_sel_skid, a WIDTH+SEL_W(+1 parity) wide one-entry skid/output register pair with valid/ready. It is instantiated once. Arbitration stays in the top module.

Test Plan:
- Reset: assert rst_n=0 for 2 cycles with all in_valid=1 -> in_ready=0, out_valid=0, out_data=0 throughout. First grant is to ch0 in mode=1 after release.
- Fixed select, NCH=2, WIDTH=8, mode=0, sel=1, in_data={8'hA5,8'h3C}, both valid, out_ready=1 -> in_ready=2'b10. Next cycle out_data=8'hA5, out_chan=1, with continuous streaming each cycle.
- Round-robin, NCH=4, all valid, out_ready=1 -> out_chan sequence 0,1,2,3,0. With only ch2 and ch0 valid from ptr=3 -> grants 0,2,0.
- Back-pressure: out_ready=0 for 3 cycles while ch0 streams 8'h11,8'h22 -> out_data holds 8'h11, skid holds 8'h22, in_ready=0. After out_ready=1 the outputs are 8'h11 then 8'h22, then new data; no loss or repeat.
- Invalid select, NCH=3, mode=0, sel=3 -> in_ready=3'b000, pending output still drains.
- WORD_SEL_PARITY_EN build, out_data=8'h07 -> out_par=1; out_data=8'h03 -> out_par=0.

Source files
------------

// File: rtl/word_sel_pkg.sv
// Shared definitions for the word select mux: mode encodings and round-robin wrap helper.
package word_sel_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Index following idx in a ring of nch channels.
  function automatic int rr_next(input int idx, input int nch);
    return (idx + 1 >= nch) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/word_sel_skid.sv
// One-entry skid plus output register with valid/ready.
// A push while the output is stalled parks the word in the skid slot, which drains first.
module word_sel_skid #(
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_push,
  input  logic [DW-1:0] in_word,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_word,
  output logic          skid_valid
);

  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_word_q, out_word_d;
  logic          skid_valid_q, skid_valid_d;
  logic [DW-1:0] skid_word_q, skid_word_d;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_word_d   = out_word_q;
    skid_valid_d = skid_valid_q;
    skid_word_d  = skid_word_q;
    if (!out_valid_q || out_ready) begin
      // Skid word is older than any new push, so it always goes out first.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_word_d   = skid_word_q;
        skid_valid_d = 1'b0;
      end else if (in_push) begin
        out_valid_d = 1'b1;
        out_word_d  = in_word;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_push) begin
      skid_valid_d = 1'b1;
      skid_word_d  = in_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_word_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_word_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_word_q   <= out_word_d;
      skid_valid_q <= skid_valid_d;
      skid_word_q  <= skid_word_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_word   = out_word_q;
  assign skid_valid = skid_valid_q;

endmodule

// File: rtl/word_sel_mux.sv
// NCH-to-1 word selector (fixed index or round-robin) feeding a registered skid output.
// Define WORD_SEL_PARITY_EN to add an out_par port carrying even parity of out_data.
module word_sel_mux
  import word_sel_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 2,
  localparam int SEL_W = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic                 mode,
  input  logic [SEL_W-1:0]     sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_W-1:0]     out_chan,
  output logic                 out_valid,
`ifdef WORD_SEL_PARITY_EN
  output logic                 out_par,
`endif
  input  logic                 out_ready
);

`ifdef WORD_SEL_PARITY_EN
  localparam int DW = WIDTH + SEL_W + 1;
`else
  localparam int DW = WIDTH + SEL_W;
`endif

  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic               grant_any;
  logic [SEL_W-1:0]   grant_idx;
  logic [2*NCH-1:0]   rot;
  logic [NCH-1:0]     rot_low;
  int                 off;
  int                 gi;
  logic               skid_valid;
  logic               xfer;
  logic [WIDTH-1:0]   word;
  logic [DW-1:0]      push_word;
  logic [DW-1:0]      out_word;

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    off       = 0;
    gi        = 0;
    rot       = {in_valid, in_valid} >> ptr_q;
    rot_low   = rot[NCH-1:0];
    if (mode == MODE_FIXED) begin
      for (int i = 0; i < NCH; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          grant_any = 1'b1;
          grant_idx = SEL_W'(i);
        end
      end
    end else begin
      // rot_low[j] is channel (ptr + j) mod NCH; the smallest set j wins.
      for (int j = NCH - 1; j >= 0; j--) begin
        if (rot_low[j]) begin
          grant_any = 1'b1;
          off       = j;
        end
      end
      gi = int'(ptr_q) + off;
      if (gi >= NCH) gi = gi - NCH;
      grant_idx = SEL_W'(gi);
    end
  end

  assign xfer = rst_n & grant_any & ~skid_valid;

  always_comb begin
    in_ready = '0;
    word     = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant_idx == SEL_W'(i)) begin
        in_ready[i] = xfer;
        word        = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (xfer && mode == MODE_RR) ptr_d = SEL_W'(rr_next(int'(grant_idx), NCH));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

`ifdef WORD_SEL_PARITY_EN
  assign push_word = {^word, grant_idx, word};
  assign out_par   = out_word[DW-1];
`else
  assign push_word = {grant_idx, word};
`endif

  word_sel_skid #(.DW(DW)) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_push    (xfer),
    .in_word    (push_word),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_word   (out_word),
    .skid_valid (skid_valid)
  );

  assign out_data = out_word[WIDTH-1:0];
  assign out_chan = out_word[WIDTH +: SEL_W];

endmodule

// File: tb/tb_word_sel_mux.sv
// Scoreboard bench for word_sel_mux with NCH=3: directed phases followed by random traffic.
module tb_word_sel_mux;
  localparam int W   = 8;
  localparam int NCH = 3;
  localparam int SW  = $clog2(NCH);
`ifdef WORD_SEL_PARITY_EN
  localparam int EW = W + SW + 1;
`else
  localparam int EW = W + SW;
`endif

  logic             clk;
  logic             rst_n;
  logic [NCH*W-1:0] in_data;
  logic [NCH-1:0]   in_valid;
  logic [NCH-1:0]   in_ready;
  logic             mode;
  logic [SW-1:0]    sel;
  logic [W-1:0]     out_data;
  logic [SW-1:0]    out_chan;
  logic             out_valid;
  logic             out_par;
  logic             out_ready;

  word_sel_mux #(.WIDTH(W), .NCH(NCH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
`ifdef WORD_SEL_PARITY_EN
    .out_par   (out_par),
`endif
    .out_ready (out_ready)
  );

`ifndef WORD_SEL_PARITY_EN
  assign out_par = 1'b0;
`endif

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];
  int  mptr      = 0;
  bit  after_rst = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [EW-1:0] pack(input int ch, input logic [W-1:0] d);
`ifdef WORD_SEL_PARITY_EN
    return {^d, SW'(ch), d};
`else
    return {SW'(ch), d};
`endif
  endfunction

  function automatic logic [EW-1:0] dut_word();
`ifdef WORD_SEL_PARITY_EN
    return {out_par, out_chan, out_data};
`else
    return {out_chan, out_data};
`endif
  endfunction

  // Reference grant: fixed index if in range and valid, else first valid walking up from mptr.
  task automatic model_grant(input logic [NCH-1:0] v, input logic m, input int s,
                             output bit ok, output int g);
    ok = 1'b0;
    g  = 0;
    if (m == 1'b0) begin
      for (int i = 0; i < NCH; i++)
        if (i == s && v[i]) begin ok = 1'b1; g = i; end
    end else begin
      for (int k = 0; k < NCH; k++)
        for (int i = 0; i < NCH; i++)
          if (!ok && i == (mptr + k) % NCH && v[i]) begin ok = 1'b1; g = i; end
    end
  endtask

  // driver: one clock of stimulus, in_ready check, and scoreboard push
  task automatic cycle(input logic rst, input logic [NCH-1:0] v, input logic [NCH*W-1:0] d,
                       input logic m, input logic [SW-1:0] s, input logic r);
    bit ok;
    int g;
    logic [NCH-1:0] exp_rdy;
    logic [W-1:0]   w;
    @(negedge clk);
    rst_n = rst; in_valid = v; in_data = d; mode = m; sel = s; out_ready = r;
    #1;
    if (after_rst) begin
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_chan", 32'(out_chan), 32'd0);
      check("rst_out_par", 32'(out_par), 32'd0);
    end
    exp_rdy = '0;
    w       = '0;
    if (!rst) begin
      exp_q.delete();
      mptr = 0;
    end else begin
      model_grant(v, m, int'(s), ok, g);
      // Two words in flight means output and skid are both occupied.
      if (ok && exp_q.size() < 2) begin
        for (int i = 0; i < NCH; i++)
          if (i == g) begin exp_rdy[i] = 1'b1; w = d[i*W +: W]; end
        exp_q.push_back(pack(g, w));
        if (m) mptr = (g + 1) % NCH;
      end
    end
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    after_rst = !rst;
  endtask

  // monitor: pops on every output handshake, checks hold while stalled
  initial begin
    logic [EW-1:0] prev;
    logic [EW-1:0] got;
    bit stalled;
    stalled = 1'b0;
    prev    = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n === 1'b1) begin
        got = dut_word();
        if (stalled) check("hold_stable", 32'(got), 32'(prev));
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out: got %0h expected none at %0t", got, $time);
          end else begin
            check("out_word", 32'(got), 32'(exp_q.pop_front()));
          end
        end
        stalled = (out_valid === 1'b1) && (out_ready === 1'b0);
        prev    = got;
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin
    logic [NCH*W-1:0] d;
    rst_n = 1'b0; in_valid = '1; in_data = '0; mode = 1'b1; sel = '0; out_ready = 1'b1;

    // reset with all channels requesting
    repeat (2) cycle(1'b0, 3'b111, {8'hC3, 8'hA5, 8'h3C}, 1'b1, 2'd0, 1'b1);

    // first round-robin grant after release goes to ch0
    cycle(1'b1, 3'b111, {8'hC3, 8'hA5, 8'h3C}, 1'b1, 2'd0, 1'b1);

    // fixed select of ch1, streaming
    for (int i = 0; i < 6; i++)
      cycle(1'b1, 3'b111, {8'hC3, 8'(8'hA5 + i), 8'h3C}, 1'b0, 2'd1, 1'b1);

    // round-robin with all valid, then only ch0 and ch2
    for (int i = 0; i < 7; i++)
      cycle(1'b1, 3'b111, {8'(8'h70 + i), 8'(8'h50 + i), 8'(8'h30 + i)}, 1'b1, 2'd0, 1'b1);
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 3'b101, {8'(8'h90 + i), 8'h00, 8'(8'h10 + i)}, 1'b1, 2'd0, 1'b1);

    // back-pressure: 11 held at output, 22 parked in skid
    cycle(1'b1, 3'b001, {8'h00, 8'h00, 8'h11}, 1'b0, 2'd0, 1'b1);
    cycle(1'b1, 3'b001, {8'h00, 8'h00, 8'h22}, 1'b0, 2'd0, 1'b0);
    repeat (2) cycle(1'b1, 3'b001, {8'h00, 8'h00, 8'h33}, 1'b0, 2'd0, 1'b0);
    repeat (3) cycle(1'b1, 3'b001, {8'h00, 8'h00, 8'h33}, 1'b0, 2'd0, 1'b1);

    // parity patterns
    cycle(1'b1, 3'b001, {8'h00, 8'h00, 8'h07}, 1'b0, 2'd0, 1'b1);
    cycle(1'b1, 3'b001, {8'h00, 8'h00, 8'h03}, 1'b0, 2'd0, 1'b1);

    // out-of-range select: no grant, pending output drains
    cycle(1'b1, 3'b111, {8'h44, 8'h55, 8'h66}, 1'b0, 2'd2, 1'b0);
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 3'b111, {8'h44, 8'h55, 8'h66}, 1'b0, 2'd3, 1'(i % 2));

    // random traffic with occasional mid-stream reset
    for (int i = 0; i < 1500; i++) begin
      d = {8'($urandom), 8'($urandom), 8'($urandom)};
      cycle(1'($urandom_range(0, 99) != 0), 3'($urandom), d, 1'($urandom_range(0, 1)),
            2'($urandom_range(0, NCH)), 1'($urandom_range(0, 3) != 0));
    end

    // drain with a bounded budget
    for (int i = 0; i < 20 && exp_q.size() > 0; i++)
      cycle(1'b1, 3'b000, '0, 1'b0, 2'd0, 1'b1);
    @(negedge clk);
    #3;
    check("drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
